sfr_file: RTL and testbench

Special Function Register file for the memory stage. It sits on the receiving end of the SFR input selection mux: it captures the selected 8-bit write data and serves registered reads back to the pipeline. It also owns the hardware-updated SFRs:
- STATUS flags
- stack pointer (SP)
- an 8-bit prescaled timer with sticky overflow and an interrupt request

---
 rtl/sfr_file_if.sv | 24 ++
 rtl/sfr_file.sv | 160 ++++++++++++++++
 tb/tb_sfr_file.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfr_file_if.sv
// Read/write bus between the SFR input selection mux and the SFR file.
// The master drives strobes, addresses and write data; the slave returns registered read data.
interface sfr_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] sfr_data_input;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output wr_en, wr_addr, sfr_data_input, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, sfr_data_input, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/sfr_file.sv
// SFR file: STATUS, SP, prescaled timer and general-purpose registers with registered reads.
// Optional STATUS/SP context shadows are built when SFR_SHADOW_EN is defined.
module sfr_file #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 8'hFF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sfr_file_if.slave             bus,
    input  logic                  flag_we,
    input  logic [3:0]            flag_in,
    input  logic                  sp_push,
    input  logic                  sp_pop,
    output logic [DATA_WIDTH-1:0] sp_out,
    input  logic                  ctx_save,
    input  logic                  ctx_restore,
    output logic                  tmr_irq
);
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam int                    NUM_REGS  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_SP      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_TCNT    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_TCTRL   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_GP0     = ADDR_WIDTH'(4);
    localparam word_t                 RSVD_MASK = word_t'(8'h8F);

    word_t      status_q, sp_q, tcnt_q, tctrl_q;
    word_t      status_d, sp_d, tcnt_d, tctrl_d;
    word_t      gp_q [4:NUM_REGS-1];
    logic [7:0] presc_q, presc_d, tick_at;
    word_t      wr_word, rd_word, rd_data_q;
    logic       rd_valid_q, tmr_irq_q;
    logic       wr_status, wr_sp, wr_tcnt, wr_tctrl, tick, tov_set;

`ifdef SFR_SHADOW_EN
    word_t sh_status_q, sh_sp_q;
`else
    logic  unused_ctx;
    assign unused_ctx = ctx_save | ctx_restore;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        wr_status = bus.wr_en && (bus.wr_addr == A_STATUS);
        wr_sp     = bus.wr_en && (bus.wr_addr == A_SP);
        wr_tcnt   = bus.wr_en && (bus.wr_addr == A_TCNT);
        wr_tctrl  = bus.wr_en && (bus.wr_addr == A_TCTRL);
        wr_word   = bus.sfr_data_input;
        if (bus.wr_addr == A_STATUS || bus.wr_addr == A_TCTRL)
            wr_word = bus.sfr_data_input & RSVD_MASK;
    end

    // Prescaler wraps at 2^PS-1; a software TMR_CNT write swallows a coincident tick.
    always_comb begin
        tick_at = (8'd1 << tctrl_q[3:1]) - 8'd1;
        tick    = tctrl_q[0] && (presc_q == tick_at);
        tov_set = tick && !wr_tcnt && (tcnt_q == '1);
        presc_d = presc_q;
        if (wr_tctrl)
            presc_d = '0;
        else if (tctrl_q[0])
            presc_d = tick ? 8'd0 : presc_q + 8'd1;
        tcnt_d = tcnt_q;
        if (wr_tcnt)
            tcnt_d = wr_word;
        else if (tick)
            tcnt_d = tcnt_q + word_t'(1);
        tctrl_d = wr_tctrl ? wr_word : tctrl_q;
    end

    // Priority, lowest first: hardware update, software write, context restore, TOV set.
    always_comb begin
        status_d = status_q;
        if (flag_we)
            status_d[3:0] = flag_in;
        if (wr_status)
            status_d = wr_word;
        case ({sp_push, sp_pop})
            2'b10:   sp_d = sp_q - word_t'(1);
            2'b01:   sp_d = sp_q + word_t'(1);
            default: sp_d = sp_q;
        endcase
        if (wr_sp)
            sp_d = wr_word;
`ifdef SFR_SHADOW_EN
        if (ctx_restore) begin
            status_d = sh_status_q;
            sp_d     = sh_sp_q;
        end
`endif
        if (tov_set)
            status_d[7] = 1'b1;
    end

    always_comb begin
        case (bus.rd_addr)
            A_STATUS: rd_word = status_q;
            A_SP:     rd_word = sp_q;
            A_TCNT:   rd_word = tcnt_q;
            A_TCTRL:  rd_word = tctrl_q;
            default:  rd_word = gp_q[bus.rd_addr];
        endcase
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr))
            rd_word = wr_word;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_q   <= '0;
            sp_q       <= SP_RESET;
            tcnt_q     <= '0;
            tctrl_q    <= '0;
            presc_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            tmr_irq_q  <= 1'b0;
        end else begin
            status_q   <= status_d;
            sp_q       <= sp_d;
            tcnt_q     <= tcnt_d;
            tctrl_q    <= tctrl_d;
            presc_q    <= presc_d;
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en)
                rd_data_q <= rd_word;
            tmr_irq_q  <= status_d[7] & tctrl_d[7];
        end
    end

    // NOTE: the general-purpose array is small and architecturally reset to zero, so it is reset here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 4; i < NUM_REGS; i++)
                gp_q[i] <= '0;
        end else if (bus.wr_en && (bus.wr_addr >= A_GP0)) begin
            gp_q[bus.wr_addr] <= bus.sfr_data_input;
        end
    end

`ifdef SFR_SHADOW_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_status_q <= '0;
            sh_sp_q     <= '0;
        end else if (ctx_save && !ctx_restore) begin
            sh_status_q <= status_q;
            sh_sp_q     <= sp_q;
        end
    end
`endif

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign sp_out       = sp_q;
    assign tmr_irq      = tmr_irq_q;
endmodule

// File: tb/tb_sfr_file.sv
// Scoreboard bench for sfr_file: directed scenarios plus random traffic against a register-array model.
// A monitor on the falling edge pops per-cycle expectations (read response, SP, irq) and compares.
module tb_sfr_file;
    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       flag_we, sp_push, sp_pop, ctx_save, ctx_restore, tmr_irq;
    logic [3:0] flag_in;
    logic [7:0] sp_out;

    always #5 clock = ~clock;

    sfr_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    sfr_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .SP_RESET(8'hFF)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .flag_we     (flag_we),
        .flag_in     (flag_in),
        .sp_push     (sp_push),
        .sp_pop      (sp_pop),
        .sp_out      (sp_out),
        .ctx_save    (ctx_save),
        .ctx_restore (ctx_restore),
        .tmr_irq     (tmr_irq)
    );

    typedef struct {
        bit       wr_en;
        bit [2:0] wa;
        bit [7:0] wd;
        bit       rd_en;
        bit [2:0] ra;
        bit       flag_we;
        bit [3:0] flag_in;
        bit       push;
        bit       pop;
        bit       save;
        bit       restore;
    } stim_t;

    typedef struct {
        int       cyc;
        bit       valid;
        bit [7:0] rd;
        bit [7:0] sp;
        bit       irq;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];

    // Reference model: the eight SFRs as a plain array plus prescaler and shadows.
    bit [7:0] m_reg [8];
    int       m_pre;
    bit [7:0] m_sh_status, m_sh_sp, m_rd;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            if (q[0].cyc < cyc) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL stale_expectation: cycle %0d now %0d", e.cyc, cyc);
            end else if (q[0].cyc == cyc) begin
                e = q.pop_front();
                check("rd_valid", bus.rd_valid, e.valid);
                check("rd_data", bus.rd_data, e.rd);
                check("sp_out", sp_out, e.sp);
                check("tmr_irq", tmr_irq, e.irq);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        return s;
    endfunction

    task automatic model_reset();
        foreach (m_reg[i]) m_reg[i] = 8'h00;
        m_reg[1]    = 8'hFF;
        m_pre       = 0;
        m_sh_status = 8'h00;
        m_sh_sp     = 8'h00;
        m_rd        = 8'h00;
    endtask

    task automatic drive(input stim_t s);
        bus.wr_en          = s.wr_en;
        bus.wr_addr        = s.wa;
        bus.sfr_data_input = s.wd;
        bus.rd_en          = s.rd_en;
        bus.rd_addr        = s.ra;
        flag_we            = s.flag_we;
        flag_in            = s.flag_in;
        sp_push            = s.push;
        sp_pop             = s.pop;
        ctx_save           = s.save;
        ctx_restore        = s.restore;
    endtask

    // Drive one cycle, advance the model by the rules, queue the expected post-edge outputs.
    task automatic step(input stim_t s);
        bit [7:0] cur [8];
        bit [7:0] n [8];
        bit [7:0] wm;
        bit       en, tick, ovf, valid;
        int       ps;
        exp_t     e;
        drive(s);
        cur  = m_reg;
        n    = m_reg;
        wm   = s.wd;
        if (s.wa == 0 || s.wa == 3) wm = wm & 8'h8F;
        en   = cur[3][0];
        ps   = int'(cur[3][3:1]);
        tick = en && (m_pre == (1 << ps) - 1);
        ovf  = tick && !(s.wr_en && s.wa == 2) && cur[2] == 8'hFF;
        valid = s.rd_en;
        if (s.rd_en) m_rd = (s.wr_en && s.wa == s.ra) ? wm : cur[s.ra];
        if (s.flag_we) n[0][3:0] = s.flag_in;
        if (s.push && !s.pop) n[1] = cur[1] - 8'd1;
        if (s.pop && !s.push) n[1] = cur[1] + 8'd1;
        if (tick) n[2] = cur[2] + 8'd1;
        if (s.wr_en) n[s.wa] = (s.wa >= 4) ? s.wd : wm;
`ifdef SFR_SHADOW_EN
        if (s.restore) begin
            n[0] = m_sh_status;
            n[1] = m_sh_sp;
        end else if (s.save) begin
            m_sh_status = cur[0];
            m_sh_sp     = cur[1];
        end
`endif
        if (ovf) n[0][7] = 1'b1;
        if (s.wr_en && s.wa == 3) m_pre = 0;
        else if (en) m_pre = tick ? 0 : m_pre + 1;
        m_reg   = n;
        e.cyc   = cyc + 1;
        e.valid = valid;
        e.rd    = m_rd;
        e.sp    = n[1];
        e.irq   = n[0][7] & n[3][7];
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input bit [2:0] a, input bit [7:0] d);
        stim_t s = idle();
        s.wr_en = 1'b1;
        s.wa    = a;
        s.wd    = d;
        step(s);
    endtask

    task automatic do_read(input bit [2:0] a);
        stim_t s = idle();
        s.rd_en = 1'b1;
        s.ra    = a;
        step(s);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #1;
        drive(idle());
        reset_n = 1'b0;
        #1;
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_tmr_irq", tmr_irq, 1'b0);
        check("rst_sp", sp_out, 8'hFF);
        model_reset();
        q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int    n;
        drive(idle());
        apply_reset();

        // Register write/read and same-cycle bypass
        do_write(3'd5, 8'h5A);
        do_read(3'd5);
        check("gp_read_valid", bus.rd_valid, 1'b1);
        check("gp_read_data", bus.rd_data, 8'h5A);
        s = idle();
        s.wr_en = 1'b1; s.wa = 3'd6; s.wd = 8'h33; s.rd_en = 1'b1; s.ra = 3'd6;
        step(s);
        check("bypass_data", bus.rd_data, 8'h33);

        // Stack pointer
        apply_reset();
        s = idle(); s.push = 1'b1;
        step(s);
        step(s);
        check("sp_push2", sp_out, 8'hFD);
        do_write(3'd1, 8'h00);
        step(s);
        check("sp_wrap_down", sp_out, 8'hFF);
        s.pop = 1'b1;
        step(s);
        check("sp_push_pop", sp_out, 8'hFF);

        // Flags vs software STATUS write
        s = idle();
        s.flag_we = 1'b1; s.flag_in = 4'b1010; s.wr_en = 1'b1; s.wa = 3'd0; s.wd = 8'h05;
        step(s);
        do_read(3'd0);
        check("status_sw_wins", bus.rd_data, 8'h05);
        s = idle(); s.flag_we = 1'b1; s.flag_in = 4'b1010;
        step(s);
        do_read(3'd0);
        check("status_flags", bus.rd_data, 8'h0A);

        // Timer overflow and irq
        do_write(3'd0, 8'h00);
        do_write(3'd3, 8'h83);
        do_write(3'd2, 8'hFE);
        n = 0;
        while (tmr_irq !== 1'b1 && n < 10) begin
            step(idle());
            n++;
        end
        check("irq_rise", tmr_irq, 1'b1);
        check("ovf_latency", n, 3);
        do_read(3'd0);
        check("tov_set", bus.rd_data, 8'h80);
        do_write(3'd0, 8'h00);
        check("irq_cleared", tmr_irq, 1'b0);
        do_write(3'd3, 8'h81);
        do_write(3'd2, 8'hFF);
        do_write(3'd0, 8'h00);
        check("set_beats_clear_irq", tmr_irq, 1'b1);
        do_read(3'd0);
        check("set_beats_clear_tov", bus.rd_data, 8'h80);

        // Reset mid-count and mid-read
        do_write(3'd2, 8'h10);
        do_read(3'd2);
        apply_reset();
        do_read(3'd3);
        check("ctrl_after_reset", bus.rd_data, 8'h00);
        repeat (3) step(idle());
        do_read(3'd2);
        check("timer_stopped", bus.rd_data, 8'h00);

`ifdef SFR_SHADOW_EN
        do_write(3'd1, 8'h40);
        do_write(3'd0, 8'h03);
        s = idle(); s.save = 1'b1;
        step(s);
        s = idle(); s.push = 1'b1; s.wr_en = 1'b1; s.wa = 3'd0; s.wd = 8'h0C;
        step(s);
        check("shadow_sp_moved", sp_out, 8'h3F);
        s = idle(); s.restore = 1'b1;
        step(s);
        check("shadow_sp_restored", sp_out, 8'h40);
        do_read(3'd0);
        check("shadow_status_restored", bus.rd_data, 8'h03);
`endif

        // Random traffic, with one reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) apply_reset();
            s = idle();
            s.wr_en = ($urandom_range(0, 9) < 3);
            s.wa    = 3'($urandom_range(0, 7));
            s.wd    = 8'($urandom);
            if (s.wa == 3'd0) s.wd[7] = 1'b0;
            if (s.wa == 3'd3)
                s.wd = {1'($urandom), 3'b000, 3'($urandom_range(0, 2)), 1'($urandom_range(0, 3) != 0)};
            s.rd_en   = ($urandom_range(0, 1) == 1);
            s.ra      = 3'($urandom_range(0, 7));
            s.flag_we = ($urandom_range(0, 3) == 0);
            s.flag_in = 4'($urandom);
            s.push    = ($urandom_range(0, 4) == 0);
            s.pop     = ($urandom_range(0, 4) == 0);
            s.save    = ($urandom_range(0, 19) == 0);
            s.restore = ($urandom_range(0, 19) == 0);
            step(s);
        end
        drive(idle());

        repeat (3) @(negedge clock);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
